serial_rx_align: RTL and testbench
==================================

# serial_rx_align

Word-aligning serial receiver for the parallel/serial link: it recovers 8-bit words from the MSB-first bit stream produced by the parallel-to-serial transmitter without being told where word boundaries are. It hunts for the idle comma (0xBC) at every bit position and locks after a run of aligned commas. Once locked, it presents data words with a valid flag and treats comma words as idle. It sits at the receive end of the link and feeds word-rate logic.

## Interface
- COMMA, 8'hBC: idle/alignment character; the transmitter sends it when its valid is low.
- LOCK_COUNT, 4: consecutive aligned commas required to lock (range 2–15).
- clk  in  1  bit-rate clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_serial_in  in  1  serial data, MSB first, one bit per clk.
- hunt_req  in  1  synchronous one-cycle request to drop lock and re-hunt.
- parallel_data  out  8  last received data word, registered.
- valid_out  out  1  high while parallel_data holds a data word from the current word slot.
- word_stb  out  1  one-clk pulse at each word boundary while locked.
- locked  out  1  high in LOCKED state.

## Operation
- Shift register shreg[7:0] <= {shreg[6:0], data_serial_in} every clk; lookahead word nxt = {shreg[6:0], data_serial_in}.
- 3-bit bit_cnt increments every clk with wrap; a word-boundary edge is any edge where bit_cnt == 7.
- HUNT:
  - nxt is compared against COMMA on every edge.
  - On a match: bit_cnt <= 0, comma_cnt <= 1, go to VERIFY.
- VERIFY:
  - At each boundary edge, if nxt == COMMA then comma_cnt++.
  - When comma_cnt reaches LOCK_COUNT, go to LOCKED.
  - If nxt != COMMA, go to HUNT with comma_cnt <= 0.
- LOCKED, at each boundary edge:
  - word_stb <= 1.
  - If nxt != COMMA: parallel_data <= nxt, valid_out <= 1.
  - If nxt == COMMA: parallel_data holds its value, valid_out <= 0.
  - Lock is held until reset or hunt_req; there is no automatic unlock.
- Protocol restriction: a data word equal to COMMA is indistinguishable from idle and is reported as idle.
- hunt_req has priority over all state activity except reset. On the next edge: state HUNT, comma_cnt 0, valid_out 0, word_stb 0, locked 0. parallel_data keeps its value.
- False comma matches in HUNT caused by data bit patterns are rejected by VERIFY.

## Timing
- Reset values:
  - All outputs 0.
  - shreg 0; bit_cnt 0; comma_cnt 0; state HUNT.
  - shreg = 0 cannot match 0xBC.
- Reset assertion clears all state immediately, including mid-word and while LOCKED.
- Latency: the last (LSB) bit of a word is present in cycle n; parallel_data, valid_out and word_stb update at the edge ending cycle n.
- parallel_data and valid_out are stable for exactly 8 clk between boundaries.
- word_stb is high for 1 clk per word.
- locked rises at the boundary edge that samples the LSB of the LOCK_COUNT-th comma. The first data output follows 8 clk later.
- Simultaneous events:
  - hunt_req on a boundary edge wins; no data is captured on that edge.
  - A comma match in HUNT on the same edge as hunt_req is ignored.

## Structure
- Shared package psp_pkg holds:
  - COMMA_K28_5 = 8'hBC
  - WORD_W = 8
  - state encodings HUNT/VERIFY/LOCKED (2-bit localparams)
- The transmitter reuses the same package.
- One natural sub-module, serial_shift8: the shift register plus the nxt lookahead and the COMMA comparator output.
- The FSM, the counters and the output registers stay in serial_rx_align.

## Test plan
- Clean lock:
  - Stimulus: bits from cycle 0: 0xBC ×4, then 0x5A.
  - Required: locked rises at edge 32; at edge 40, parallel_data = 0x5A, valid_out = 1, word_stb pulses.
- Bit offset:
  - Stimulus: 3 bits 1,0,1, then 0xBC ×4, then 0xA3.
  - Required: locked rises at edge 35; parallel_data = 0xA3 at edge 43 (correct alignment).
- Broken verify:
  - Stimulus: 0xBC ×2, 0x00, then 0xBC ×4.
  - Required: no lock after the first two commas; locked rises only at the LSB of the 4th comma of the second run.
- Idle within data:
  - Stimulus: locked, then 0x11, 0xBC, 0x22.
  - Required: valid_out 1, 0, 1; parallel_data 0x11, 0x11, 0x22; word_stb pulses for all three words.
- hunt_req:
  - Stimulus: pulse hunt_req while locked.
  - Required: locked = 0 and valid_out = 0 after the next edge; relock after 4 further aligned commas.
- Reset mid-operation:
  - Stimulus: drive reset low for 3 clk mid-word while locked.
  - Required: all outputs 0 immediately; state HUNT; relock requires 4 fresh commas.

Source files
------------

// File: rtl/psp_pkg.sv
// Shared definitions for the parallel/serial link: comma character, word
// width and receiver state encodings. Used by both ends of the link.
package psp_pkg;

  localparam int WORD_W = 8;

  // K28.5-style idle/alignment character
  localparam logic [WORD_W-1:0] COMMA_K28_5 = 8'hBC;

  // Receiver alignment state encodings
  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    HUNT   = ST_HUNT,
    VERIFY = ST_VERIFY,
    LOCKED = ST_LOCKED
  } rx_state_e;

  // True when a word is the idle/alignment character
  function automatic logic is_comma(input logic [WORD_W-1:0] word);
    return word == COMMA_K28_5;
  endfunction

endpackage

// File: rtl/serial_shift8.sv
// Serial-in shifter producing the 8-bit lookahead window nxt (the word that
// the shift register will hold after this edge) and its comma comparison.
// Only the 7 history bits are stored: the oldest bit of a full 8-bit shifter
// has already left the comparison window by the time it could be read.
module serial_shift8
  import psp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              data_serial_in,
  output logic [WORD_W-1:0] nxt,
  output logic              comma_match
);

  logic [WORD_W-2:0] shreg_reg;

  // Newest bit enters at the LSB, so the stream is assembled MSB first
  assign nxt         = {shreg_reg, data_serial_in};
  assign comma_match = is_comma(nxt);

  // Bit history; cleared to zero, which can never look like a comma
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_reg <= '0;
    end else begin
      shreg_reg <= nxt[WORD_W-2:0];
    end
  end

endmodule

// File: rtl/serial_rx_align.sv
// Word-aligning serial receiver. Hunts for the comma at every bit position,
// verifies LOCK_COUNT consecutive aligned commas, then delivers data words
// at every 8-bit boundary, treating commas as idle slots.
module serial_rx_align
  import psp_pkg::*;
#(
  parameter int LOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_serial_in,
  input  logic              hunt_req,
  output logic [WORD_W-1:0] parallel_data,
  output logic              valid_out,
  output logic              word_stb,
  output logic              locked
);

  // comma_cnt value at which the next aligned comma completes the lock
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);

  rx_state_e         state_reg,     state_next;
  logic [2:0]        bit_cnt_reg,   bit_cnt_next;
  logic [3:0]        comma_cnt_reg, comma_cnt_next;
  logic [WORD_W-1:0] data_reg,      data_next;
  logic              valid_reg,     valid_next;
  logic              stb_reg,       stb_next;

  logic [WORD_W-1:0] nxt;
  logic              comma_match;
  logic              boundary;

  serial_shift8 u_shift (
    .clk            (clk),
    .reset          (reset),
    .data_serial_in (data_serial_in),
    .nxt            (nxt),
    .comma_match    (comma_match)
  );

  // The edge that samples the last bit of a word slot
  assign boundary = (bit_cnt_reg == 3'd7);

  // Next-state, counter and output-register logic
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg + 3'd1;
    comma_cnt_next = comma_cnt_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    stb_next       = 1'b0;

    if (hunt_req) begin
      // Re-hunt overrides everything, including a capture or comma match
      // landing on this same edge; captured data is left in place.
      state_next     = HUNT;
      comma_cnt_next = 4'd0;
      valid_next     = 1'b0;
    end else begin
      unique case (state_reg)
        HUNT: begin
          if (comma_match) begin
            // Realign the word clock so this comma's LSB ends a slot
            bit_cnt_next   = 3'd0;
            comma_cnt_next = 4'd1;
            state_next     = VERIFY;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (comma_match) begin
              comma_cnt_next = comma_cnt_reg + 4'd1;
              if (comma_cnt_reg == LOCK_LAST) begin
                state_next = LOCKED;
              end
            end else begin
              // Data-pattern false match or broken run: start over
              comma_cnt_next = 4'd0;
              state_next     = HUNT;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            stb_next = 1'b1;
            if (comma_match) begin
              valid_next = 1'b0;
            end else begin
              data_next  = nxt;
              valid_next = 1'b1;
            end
          end
        end
        default: begin
          state_next = HUNT;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= HUNT;
      bit_cnt_reg   <= 3'd0;
      comma_cnt_reg <= 4'd0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      stb_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      comma_cnt_reg <= comma_cnt_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      stb_reg       <= stb_next;
    end
  end

  assign parallel_data = data_reg;
  assign valid_out     = valid_reg;
  assign word_stb      = stb_reg;
  assign locked        = (state_reg == LOCKED);

endmodule

// File: tb/tb_serial_rx_align.sv
// Directed testbench for serial_rx_align: lock acquisition, bit offset,
// broken verify, idle slots within data, hunt_req and asynchronous reset.
module tb_serial_rx_align;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_serial_in = 1'b0;
  logic       hunt_req = 1'b0;
  logic [7:0] parallel_data;
  logic       valid_out;
  logic       word_stb;
  logic       locked;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_pd_q    = 8'h00;
  logic       exp_valid_q = 1'b0;

  typedef struct {
    logic [7:0] word;
    logic       exp_valid;
    logic [7:0] exp_pd;
  } vec_t;

  vec_t vecs [9];

  serial_rx_align #(.LOCK_COUNT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_serial_in (data_serial_in),
    .hunt_req       (hunt_req),
    .parallel_data  (parallel_data),
    .valid_out      (valid_out),
    .word_stb       (word_stb),
    .locked         (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one bit, let the rising edge take it, sample 1 ns later
  task automatic tick(input logic b);
    data_serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick(b[i]);
  endtask

  // Send n commas; locked must stay low except possibly after the last one
  task automatic send_commas(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      send_byte(8'hBC);
      if (k < n - 1) check({tag, "_no_early_lock"}, {7'd0, locked}, 8'd0);
    end
  endtask

  // One locked word slot: outputs must hold mid-word and update at the boundary
  task automatic run_word(input vec_t v, input string tag);
    for (int i = 7; i >= 0; i--) begin
      tick(v.word[i]);
      if (i == 4) begin
        check({tag, "_mid_stb"},   {7'd0, word_stb},  8'd0);
        check({tag, "_mid_valid"}, {7'd0, valid_out}, {7'd0, exp_valid_q});
        check({tag, "_mid_pd"},    parallel_data,     exp_pd_q);
      end
    end
    check({tag, "_stb"},    {7'd0, word_stb},  8'd1);
    check({tag, "_valid"},  {7'd0, valid_out}, {7'd0, v.exp_valid});
    check({tag, "_pd"},     parallel_data,     v.exp_pd);
    check({tag, "_locked"}, {7'd0, locked},    8'd1);
    $display("word %s sent=%h pd=%h valid=%b stb=%b", tag, v.word, parallel_data, valid_out, word_stb);
    exp_valid_q = v.exp_valid;
    exp_pd_q    = v.exp_pd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pd"},     parallel_data,     8'd0);
    check({tag, "_valid"},  {7'd0, valid_out}, 8'd0);
    check({tag, "_stb"},    {7'd0, word_stb},  8'd0);
    check({tag, "_locked"}, {7'd0, locked},    8'd0);
  endtask

  // Assert reset between edges, check it acts immediately, hold 3 clk, release
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero(tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_pd_q    = 8'h00;
    exp_valid_q = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 8'h5A};
    vecs[1] = '{8'h11, 1'b1, 8'h11};
    vecs[2] = '{8'hBC, 1'b0, 8'h11};
    vecs[3] = '{8'h22, 1'b1, 8'h22};
    vecs[4] = '{8'hBC, 1'b0, 8'h22};
    vecs[5] = '{8'hBC, 1'b0, 8'h22};
    vecs[6] = '{8'h00, 1'b1, 8'h00};
    vecs[7] = '{8'hFF, 1'b1, 8'hFF};
    vecs[8] = '{8'h3C, 1'b1, 8'h3C};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Clean lock: four commas from cycle 0, lock at edge 32
    send_commas(4, "clean");
    check("clean_lock_edge32", {7'd0, locked},   8'd1);
    check("clean_lock_stb",    {7'd0, word_stb}, 8'd0);
    check("clean_lock_valid",  {7'd0, valid_out}, 8'd0);

    // Data and idle slots while locked
    for (int n = 0; n < 9; n++) run_word(vecs[n], $sformatf("vec%0d", n));

    // hunt_req on a data boundary: no capture, lock dropped, pd kept
    for (int i = 7; i >= 1; i--) tick(1'(8'h77 >> i));
    hunt_req = 1'b1;
    tick(1'b1);
    hunt_req = 1'b0;
    check("hunt_locked", {7'd0, locked},    8'd0);
    check("hunt_valid",  {7'd0, valid_out}, 8'd0);
    check("hunt_stb",    {7'd0, word_stb},  8'd0);
    check("hunt_pd_kept", parallel_data,    8'h3C);
    exp_valid_q = 1'b0;
    send_commas(4, "relock");
    check("relock_locked", {7'd0, locked}, 8'd1);
    run_word('{8'h96, 1'b1, 8'h96}, "relock_data");

    // Reset mid-word while locked, then relock with a 3-bit offset
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    reset_pulse("midreset");
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    send_commas(4, "offset");
    check("offset_lock_edge35", {7'd0, locked}, 8'd1);
    run_word('{8'hA3, 1'b1, 8'hA3}, "offset_data");

    // Broken verify: two commas, a zero word, then a fresh run of four
    reset_pulse("bv_reset");
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h00);
    check("bv_after_break", {7'd0, locked}, 8'd0);
    send_commas(4, "bv_run2");
    check("bv_lock", {7'd0, locked}, 8'd1);
    run_word('{8'hC5, 1'b1, 8'hC5}, "bv_data");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
